seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider.sv | 110 +++++++++++
 tb/tb_seq_divider.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Request/response bundle for the sequential divider: operands and control in,
// status and results out.
interface seq_divider_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              signed_op;
  logic              flush;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] rem;
  logic              div_zero;

  modport master (
    output start, signed_op, flush, dividend, divisor,
    input  busy, done, quot, rem, div_zero
  );

  modport slave (
    input  start, signed_op, flush, dividend, divisor,
    output busy, done, quot, rem, div_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring radix-2 divider (DIV/DIVU): one quotient bit per cycle,
// magnitudes divided unsigned, signs applied in a single fixup cycle.
module seq_divider #(
  parameter int DATA_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  seq_divider_if.slave  div_if
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q, quot_q, dvs_q;
  logic              sgn_q, neg_dd_q, neg_dv_q;
  logic [DATA_W-1:0] quot_out_q, rem_out_q;
  logic              dz_out_q;
  logic              busy, done, accept;

  function automatic logic [DATA_W-1:0] mag(input logic s, input logic [DATA_W-1:0] v);
    return (s && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  // Shifted partial remainder needs DATA_W+1 bits; its MSB set means it already
  // exceeds any DATA_W-bit divisor, so the borrow alone is not enough.
  logic [DATA_W:0]   shifted, diff;
  logic              ge;
  assign shifted = {rem_q, quot_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = shifted[DATA_W] | ~diff[DATA_W];

  logic [DATA_W-1:0] quot_fix, rem_fix;
  logic              dz;
  assign dz       = (dvs_q == '0);
  assign rem_fix  = (sgn_q && neg_dd_q) ? (~rem_q + 1'b1) : rem_q;
  assign quot_fix = dz ? '1 :
                    (sgn_q && (neg_dd_q ^ neg_dv_q)) ? (~quot_q + 1'b1) : quot_q;

  assign accept = (state_q == S_IDLE) && div_if.start && !div_if.flush;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  if (div_if.flush) state_d = S_IDLE;
               else if (cnt_q == LAST_ITER) state_d = S_FIXUP;
      S_FIXUP: state_d = div_if.flush ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      sgn_q      <= 1'b0;
      neg_dd_q   <= 1'b0;
      neg_dv_q   <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      dz_out_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q    <= '0;
        rem_q    <= '0;
        quot_q   <= mag(div_if.signed_op, div_if.dividend);
        dvs_q    <= mag(div_if.signed_op, div_if.divisor);
        sgn_q    <= div_if.signed_op;
        neg_dd_q <= div_if.dividend[DATA_W-1];
        neg_dv_q <= div_if.divisor[DATA_W-1];
      end
      if (state_q == S_CALC && !div_if.flush) begin
        cnt_q  <= cnt_q + 1'b1;
        rem_q  <= ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quot_q <= {quot_q[DATA_W-2:0], ge};
      end
      // A zero divisor leaves the dividend magnitude in rem_q; re-signing it
      // reproduces the dividend as sampled.
      if (state_q == S_FIXUP && !div_if.flush) begin
        quot_out_q <= quot_fix;
        rem_out_q  <= rem_fix;
        dz_out_q   <= dz;
      end
    end
  end

  assign div_if.busy     = busy;
  assign div_if.done     = done;
  assign div_if.quot     = quot_out_q;
  assign div_if.rem      = rem_out_q;
  assign div_if.div_zero = dz_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table through a scoreboard queue,
// plus hand sequences for reset, flush and start-while-busy.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_divider_if #(.DATA_W(32)) dif ();

  seq_divider #(.DATA_W(32)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .div_if (dif.slave)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  always @(negedge clk) if (dif.done) done_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, ".quot"}, dif.quot, e.q);
      chk({nm, ".rem"},  dif.rem,  e.r);
      chk({nm, ".dz"},   {31'd0, dif.div_zero}, {31'd0, e.dz});
    end
  endtask

  // Drive one op, wait for Done with a cycle bound, compare latency and results.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] r, input logic dz,
                       input string nm);
    int n, bc;
    exp_t e;
    @(negedge clk);
    dif.start = 1'b1; dif.signed_op = s; dif.dividend = a; dif.divisor = b;
    e.q = q; e.r = r; e.dz = dz;
    sb.push_back(e);
    @(posedge clk); #1;
    dif.start = 1'b0;
    n = 0; bc = 0;
    while (!dif.done && n < 60) begin
      if (dif.busy) bc++;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, ".latency"}, n, 33);
    chk({nm, ".busy_cycles"}, bc, 33);
    chk({nm, ".busy_in_done"}, {31'd0, dif.busy}, 32'd1);
    pop_cmp(nm);
    @(posedge clk); #1;
    chk({nm, ".done_pulse"}, {31'd0, dif.done}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    int d0, n;
    exp_t e;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[5]  = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[7]  = '{1'b1, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[9]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
    vecs[10] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
    vecs[11] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};

    dif.start = 1'b0; dif.signed_op = 1'b0; dif.flush = 1'b0;
    dif.dividend = '0; dif.divisor = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", {31'd0, dif.busy}, 32'd0);
    chk("rst.done", {31'd0, dif.done}, 32'd0);
    chk("rst.quot", dif.quot, 32'd0);
    chk("rst.rem",  dif.rem,  32'd0);
    chk("rst.dz",   {31'd0, dif.div_zero}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
            $sformatf("vec%0d", i));

    // Reset sampled at CALC iteration 10 of 1000/3.
    d0 = done_cnt;
    @(negedge clk);
    dif.start = 1'b1; dif.signed_op = 1'b0; dif.dividend = 32'd1000; dif.divisor = 32'd3;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.busy", {31'd0, dif.busy}, 32'd0);
    chk("midrst.done", {31'd0, dif.done}, 32'd0);
    chk("midrst.quot", dif.quot, 32'd0);
    chk("midrst.rem",  dif.rem,  32'd0);
    chk("midrst.dz",   {31'd0, dif.div_zero}, 32'd0);
    repeat (40) @(posedge clk);
    #1 chk("midrst.no_done", done_cnt - d0, 0);
    do_op(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, "after_rst");

    // Start held high with other operands throughout Busy and in DONE.
    d0 = done_cnt;
    @(negedge clk);
    dif.start = 1'b1; dif.signed_op = 1'b0; dif.dividend = 32'd20; dif.divisor = 32'd6;
    e.q = 32'd3; e.r = 32'd2; e.dz = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    dif.signed_op = 1'b1; dif.dividend = 32'd50; dif.divisor = 32'd5;
    n = 0;
    while (!dif.done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busystart.latency", n, 33);
    pop_cmp("busystart");
    @(posedge clk); #1;
    dif.start = 1'b0;
    chk("busystart.idle", {31'd0, dif.busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1 chk("busystart.one_done", done_cnt - d0, 1);
    chk("busystart.quot_held", dif.quot, 32'd3);

    // Flush at iteration 5: back to IDLE, no Done, prior results held.
    d0 = done_cnt;
    @(negedge clk);
    dif.start = 1'b1; dif.signed_op = 1'b0; dif.dividend = 32'd1000; dif.divisor = 32'd7;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 dif.flush = 1'b1;
    @(posedge clk); #1;
    dif.flush = 1'b0;
    chk("flush.busy", {31'd0, dif.busy}, 32'd0);
    chk("flush.quot", dif.quot, 32'd3);
    chk("flush.rem",  dif.rem,  32'd2);
    repeat (40) @(posedge clk);
    #1 chk("flush.no_done", done_cnt - d0, 0);

    // Flush wins over Start in IDLE.
    @(negedge clk);
    dif.start = 1'b1; dif.flush = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0; dif.flush = 1'b0;
    chk("flush_start.busy", {31'd0, dif.busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
